regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two writeback sources, ALU (A) and load unit (M).
//  Tracks pending writes in a 16-bit busy scoreboard and raises an operand-hazard stall for decode.
//  Sits between the execute/memory stages and the register file.
//  Its registered write outputs feed the register file's writeEnable/dReg/wrData, which the file samples on the following negedge.
// PARAMETERS
//  STARVE_LIMIT  3   consecutive lost cycles for A before A is forced to win; legal 1..15
//  DATA_W        32  writeback data width
// PORTS
//  clk            in   1       system clock; all state updates on posedge
//  reset          in   1       synchronous, active-high reset
//  alu_valid      in   1       A has a result to write
//  alu_dest       in   4       A destination register
//  alu_data       in   DATA_W  A result
//  alu_ready      out  1       A transfer accepted this cycle (comb)
//  mem_valid      in   1       M has load data to write
//  mem_dest       in   4       M destination register
//  mem_data       in   DATA_W  M load data
//  mem_ready      out  1       M transfer accepted this cycle (comb)
//  alloc_valid    in   1       decode issued an instr that will write alloc_dest
//  alloc_dest     in   4       register to mark busy
//  rd_op1         in   4       decode source operand 1
//  rd_op2         in   4       decode source operand 2
//  rd_use1        in   1       operand 1 is read by the instr
//  rd_use2        in   1       operand 2 is read by the instr
//  hazard_stall   out  1       decode must stall (comb)
//  writeEnable    out  1       register file write enable (registered)
//  dReg           out  4       register file write address (registered)
//  wrData         out  DATA_W  register file write data (registered)
//  busy_vec       out  16      scoreboard state (registered)
// BEHAVIOUR
//  - Reset: writeEnable=0, dReg=0, wrData=0, busy_vec=0, age=0; alu_ready=mem_ready=0 while reset is high; in-flight requests are dropped, not replayed.
//  - Handshake: a transfer occurs on valid&ready. Ready never depends on the other side's ready.
//    At most one grant per cycle. A source holds valid/dest/data stable until its transfer.
//  - Arbitration: default M wins. A 4-bit counter `age` increments each cycle A is valid and not granted (saturates at 15).
//    If age >= STARVE_LIMIT and A is valid, A wins; age returns to 0 on any A grant, and also when A is not valid.
//  - Only one valid: that source wins regardless of age.
//  - Latency: on a grant at posedge N, the write outputs hold the request from N+1 until posedge N+1.
//    writeEnable is a single-cycle pulse; with no grant it is 0, and dReg/wrData hold their last values.
//  - Protected registers 14 and 15: a request to them is accepted (ready=1 if granted) but writeEnable stays 0.
//    alloc to 14/15 is ignored (busy bit never set).
//  - Scoreboard: on posedge, alloc_valid sets busy[alloc_dest]; a granted write to d clears busy[d].
//    Same register set and cleared in one cycle -> set wins (newer producer).
//    A write to a non-busy register is legal; busy stays 0.
//  - Stall: hazard_stall = (rd_use1 & busy[rd_op1]) | (rd_use2 & busy[rd_op2]).
//    There is no bypass, so it stays high through the cycle the clearing grant occurs and drops the next cycle.
//  - hazard_stall does not gate alloc_valid; decode must not assert alloc while stalled.
// TESTING
//  1. Reset, then alu_valid=1, dest=3, data=0xA5: alu_ready=1 same cycle; next cycle writeEnable=1, dReg=3, wrData=0xA5; following cycle writeEnable=0.
//  2. A and M both valid continuously (dests 1 and 2), STARVE_LIMIT=3: grants M,M,M,A,M,M,M,A...; no cycle has two readies.
//  3. alloc_valid dest=5, then rd_op1=5 with use1=1: hazard_stall=1 until the cycle after M writes reg 5, then 0; busy_vec[5] goes 1 -> 0.
//  4. alloc dest=7 and a granted write to 7 in the same cycle: busy_vec[7]=1 afterwards.
//  5. Request to dest=14, data=0xFFFF: ready=1, writeEnable stays 0; alloc dest=15: busy_vec stays 0.
//  6. reset asserted while both are valid and busy_vec=0x00F0: next cycle all outputs 0, readies 0, busy_vec=0, age=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between ALU (A) and load unit (M),
// keeps a busy scoreboard of pending destinations and raises the decode operand-hazard stall.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [3:0]        alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [3:0]        mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_dest,
    input  logic [3:0]        rd_op1,
    input  logic [3:0]        rd_op2,
    input  logic              rd_use1,
    input  logic              rd_use2,
    output logic              hazard_stall,
    output logic              writeEnable,
    output logic [3:0]        dReg,
    output logic [DATA_W-1:0] wrData,
    output logic [15:0]       busy_vec
);

    localparam logic [3:0] AGE_MAX = 4'd15;
    localparam logic [3:0] STARVE  = 4'(STARVE_LIMIT);

    logic [3:0]        age_q, age_d;
    logic [15:0]       busy_q, busy_d;
    logic              we_q, we_d;
    logic [3:0]        dreg_q, dreg_d;
    logic [DATA_W-1:0] wrdata_q, wrdata_d;

    logic              a_win, m_win, grant, g_prot, alloc_prot;
    logic [3:0]        g_dest;
    logic [DATA_W-1:0] g_data;

    // M wins by default; A takes the port once it has lost STARVE_LIMIT cycles in a row.
    always_comb begin
        a_win = alu_valid & (~mem_valid | (age_q >= STARVE));
        m_win = mem_valid & ~a_win;
    end

    assign alu_ready = a_win & ~reset;
    assign mem_ready = m_win & ~reset;
    assign grant     = alu_ready | mem_ready;
    assign g_dest    = alu_ready ? alu_dest : mem_dest;
    assign g_data    = alu_ready ? alu_data : mem_data;

    // Registers 14 and 15 are read-only: writes are consumed but never reach the file.
    assign g_prot     = (g_dest[3:1] == 3'b111);
    assign alloc_prot = (alloc_dest[3:1] == 3'b111);

    always_comb begin
        age_d = age_q;
        if (!alu_valid || alu_ready)
            age_d = 4'd0;
        else if (age_q != AGE_MAX)
            age_d = age_q + 4'd1;
    end

    // Clear first, then set, so a same-cycle allocation (newer producer) keeps the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (grant)
            busy_d[g_dest] = 1'b0;
        if (alloc_valid && !alloc_prot)
            busy_d[alloc_dest] = 1'b1;
    end

    always_comb begin
        we_d     = grant & ~g_prot;
        dreg_d   = dreg_q;
        wrdata_d = wrdata_q;
        if (grant) begin
            dreg_d   = g_dest;
            wrdata_d = g_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            age_q    <= 4'd0;
            busy_q   <= 16'd0;
            we_q     <= 1'b0;
            dreg_q   <= 4'd0;
            wrdata_q <= '0;
        end else begin
            age_q    <= age_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            dreg_q   <= dreg_d;
            wrdata_q <= wrdata_d;
        end
    end

    // No bypass: the stall holds through the clearing grant and drops once busy_q updates.
    assign hazard_stall = (rd_use1 & busy_q[rd_op1]) | (rd_use2 & busy_q[rd_op2]);

    assign writeEnable = we_q;
    assign dReg        = dreg_q;
    assign wrData      = wrdata_q;
    assign busy_vec    = busy_q;

endmodule
